// File: rtl/execute_alu_scheduler_if.sv
// Pack types and the port bundle of execute_alu_scheduler. The scheduler
// connects through the slave modport; its environment uses master.
package execute_alu_scheduler_pkg;

    typedef struct packed {
        logic        enable;
        logic [31:0] value;
        logic        valid;
        logic [31:0] pc;
        logic [6:0]  rob_id;
        logic        rd_enable;
        logic [4:0]  rd;
        logic [5:0]  rd_phy;
        logic [31:0] src1_value;
        logic [31:0] src2_value;
        logic [31:0] imm;
        logic [3:0]  op;
        logic [3:0]  sub_op;
    } issue_execute_pack_t;

    typedef struct packed {
        logic enable;
        logic flush;
    } commit_feedback_pack_t;

endpackage

interface execute_alu_scheduler_if #(
    parameter int unsigned REQ_NUM = 2
);
    import execute_alu_scheduler_pkg::*;

    issue_execute_pack_t   req_data_out [REQ_NUM];
    logic                  req_data_out_valid [REQ_NUM];
    logic                  req_pop [REQ_NUM];
    issue_execute_pack_t   issue_alu_fifo_data_out;
    logic                  issue_alu_fifo_data_out_valid;
    logic                  issue_alu_fifo_pop;
    commit_feedback_pack_t commit_feedback_pack;
    logic [31:0]           perf_grant_count [REQ_NUM];
    logic [31:0]           perf_stall_count;

    modport slave (
        input  req_data_out,
        input  req_data_out_valid,
        output req_pop,
        output issue_alu_fifo_data_out,
        output issue_alu_fifo_data_out_valid,
        input  issue_alu_fifo_pop,
        input  commit_feedback_pack,
        output perf_grant_count,
        output perf_stall_count
    );

    modport master (
        output req_data_out,
        output req_data_out_valid,
        input  req_pop,
        input  issue_alu_fifo_data_out,
        input  issue_alu_fifo_data_out_valid,
        output issue_alu_fifo_pop,
        output commit_feedback_pack,
        input  perf_grant_count,
        input  perf_stall_count
    );

endinterface

// File: rtl/execute_alu_scheduler.sv
// Round-robin arbiter sharing one execute_alu among REQ_NUM issue queues via a
// one-entry holding register. ALU_SCHED_PERF_COUNTER_EN enables the perf counters.
module execute_alu_scheduler
    import execute_alu_scheduler_pkg::*;
#(
    parameter int unsigned REQ_NUM = 2,
    parameter int unsigned PTR_W   = $clog2(REQ_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    execute_alu_scheduler_if.slave sched_if
);

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

    typedef enum logic [1:0] {
        PH_EMPTY,
        PH_FULL,
        PH_STALL
    } phase_e;

    hold_state_e         hold_state_q, hold_state_d;
    issue_execute_pack_t hold_data_q, hold_data_d;
    logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;

    phase_e              phase;
    logic                flush;
    logic                load_en;
    logic                grant_found;
    logic                grant_fire;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand_idx;

    logic                req_valid [REQ_NUM];
    issue_execute_pack_t req_data  [REQ_NUM];
    logic                req_pop   [REQ_NUM];

    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_req
        assign req_valid[gi]        = sched_if.req_data_out_valid[gi];
        assign req_data[gi]         = sched_if.req_data_out[gi];
        assign sched_if.req_pop[gi] = req_pop[gi];
    end

    assign flush = sched_if.commit_feedback_pack.enable & sched_if.commit_feedback_pack.flush;

    always_comb begin
        phase = PH_EMPTY;
        if (hold_state_q == HOLD_FULL) begin
            phase = sched_if.issue_alu_fifo_pop ? PH_FULL : PH_STALL;
        end
    end

    assign load_en = ~flush & (phase != PH_STALL);

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            cand_idx = PTR_W'((32'(rr_ptr_q) + i) % REQ_NUM);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Reset gates the pops so nothing leaves a requester while rst is low.
    assign grant_fire = rst & load_en & grant_found;

    always_comb begin
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            req_pop[i] = grant_fire && (grant_idx == PTR_W'(i));
        end
    end

    // A grant implies load_en without flush; otherwise flush or an idle load empties.
    always_comb begin
        hold_state_d = hold_state_q;
        hold_data_d  = hold_data_q;
        rr_ptr_d     = rr_ptr_q;
        if (grant_fire) begin
            hold_state_d = HOLD_FULL;
            hold_data_d  = req_data[grant_idx];
            rr_ptr_d     = PTR_W'((32'(grant_idx) + 32'd1) % REQ_NUM);
        end else if (flush || load_en) begin
            hold_state_d = HOLD_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_state_q <= HOLD_EMPTY;
            hold_data_q  <= '0;
            rr_ptr_q     <= '0;
        end else begin
            hold_state_q <= hold_state_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign sched_if.issue_alu_fifo_data_out       = hold_data_q;
    assign sched_if.issue_alu_fifo_data_out_valid = (hold_state_q == HOLD_FULL);

`ifdef ALU_SCHED_PERF_COUNTER_EN
    logic [31:0] grant_cnt_q [REQ_NUM];
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REQ_NUM; i++) begin
                grant_cnt_q[i] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            if (grant_fire) begin
                grant_cnt_q[grant_idx] <= grant_cnt_q[grant_idx] + 32'd1;
            end
            if (phase == PH_STALL) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_perf
        assign sched_if.perf_grant_count[gi] = grant_cnt_q[gi];
    end
    assign sched_if.perf_stall_count = stall_cnt_q;
`else
    for (genvar gi = 0; gi < REQ_NUM; gi++) begin : g_perf
        assign sched_if.perf_grant_count[gi] = '0;
    end
    assign sched_if.perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_execute_alu_scheduler.sv
// Directed plus randomized bench for execute_alu_scheduler against a
// behavioural round-robin / holding-register model.
module tb_execute_alu_scheduler;
    import execute_alu_scheduler_pkg::*;

    localparam int unsigned REQ = 2;
`ifdef ALU_SCHED_PERF_COUNTER_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    execute_alu_scheduler_if #(.REQ_NUM(REQ)) sched_if ();

    execute_alu_scheduler #(.REQ_NUM(REQ)) dut (
        .clk      (clk),
        .rst      (rst),
        .sched_if (sched_if)
    );

    int n_assert = 0;
    int n_fail   = 0;

    issue_execute_pack_t head [REQ];
    bit                  hvld [REQ];
    bit                  pop_in;
    bit                  cf_en;
    bit                  cf_fl;

    int                  m_ptr;
    bit                  m_hv;
    issue_execute_pack_t m_data;
    int unsigned         m_gc [REQ];
    int unsigned         m_stall;
    int                  last_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pack(input string tag, input issue_execute_pack_t obs, input issue_execute_pack_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic issue_execute_pack_t rand_pack();
        logic [$bits(issue_execute_pack_t)-1:0] v;
        for (int i = 0; i < $bits(issue_execute_pack_t); i++) v[i] = 1'($urandom_range(0, 1));
        return issue_execute_pack_t'(v);
    endfunction

    function automatic issue_execute_pack_t pc_pack(input logic [31:0] pc);
        issue_execute_pack_t p;
        p = rand_pack();
        p.pc = pc;
        return p;
    endfunction

    // Round-robin search: first valid requester from ptr upward, wrapping.
    function automatic int pick(input int ptr);
        for (int k = 0; k < REQ; k++) begin
            if (hvld[(ptr + k) % REQ]) return (ptr + k) % REQ;
        end
        return -1;
    endfunction

    task automatic apply();
        for (int i = 0; i < REQ; i++) begin
            sched_if.req_data_out[i]       = head[i];
            sched_if.req_data_out_valid[i] = hvld[i];
        end
        sched_if.issue_alu_fifo_pop          = pop_in;
        sched_if.commit_feedback_pack.enable = cf_en;
        sched_if.commit_feedback_pack.flush  = cf_fl;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_hv    = 1'b0;
        m_data  = '0;
        m_stall = 0;
        for (int i = 0; i < REQ; i++) m_gc[i] = 0;
    endtask

    // One clock: drive at posedge+1, check at negedge, advance model, return at posedge+1.
    task automatic step();
        int g;
        bit fl;
        bit le;
        apply();
        @(negedge clk);
        fl = cf_en && cf_fl;
        le = !fl && (!m_hv || pop_in);
        g  = le ? pick(m_ptr) : -1;
        for (int k = 0; k < REQ; k++) begin
            chk($sformatf("req_pop[%0d]", k), 64'(sched_if.req_pop[k]), 64'(g == k));
            chk($sformatf("perf_grant[%0d]", k), 64'(sched_if.perf_grant_count[k]), PERF ? 64'(m_gc[k]) : 64'd0);
        end
        chk("out_valid", 64'(sched_if.issue_alu_fifo_data_out_valid), 64'(m_hv));
        if (m_hv) chk_pack("out_data", sched_if.issue_alu_fifo_data_out, m_data);
        chk("perf_stall", 64'(sched_if.perf_stall_count), PERF ? 64'(m_stall) : 64'd0);

        if (m_hv && !pop_in) m_stall++;
        if (fl) begin
            m_hv = 1'b0;
        end else if (le) begin
            if (g >= 0) begin
                m_data = head[g];
                m_hv   = 1'b1;
                m_ptr  = (g + 1) % REQ;
                m_gc[g]++;
            end else begin
                m_hv = 1'b0;
            end
        end
        last_grant = g;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted between edges with requests valid.
    task automatic do_reset();
        hvld[0] = 1'b1;
        hvld[1] = 1'b1;
        apply();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(sched_if.issue_alu_fifo_data_out_valid), 64'd0);
        chk_pack("rst_data", sched_if.issue_alu_fifo_data_out, '0);
        for (int k = 0; k < REQ; k++) begin
            chk($sformatf("rst_pop[%0d]", k), 64'(sched_if.req_pop[k]), 64'd0);
        end
        chk("rst_stall", 64'(sched_if.perf_stall_count), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < REQ; i++) begin
            head[i] = '0;
            hvld[i] = 1'b0;
        end
        pop_in = 1'b0;
        cf_en  = 1'b0;
        cf_fl  = 1'b0;
        last_grant = -1;
        model_reset();
        apply();

        do_reset();

        // Single request on requester 1.
        hvld[0] = 1'b0;
        hvld[1] = 1'b1;
        head[1] = pc_pack(32'h80);
        pop_in  = 1'b1;
        step();
        chk("single_grant", 64'(last_grant), 64'd1);
        hvld[1] = 1'b0;
        chk("single_pc", 64'(sched_if.issue_alu_fifo_data_out.pc), 64'h80);
        chk("single_valid", 64'(sched_if.issue_alu_fifo_data_out_valid), 64'd1);
        step();

        // Round-robin, both valid, back-to-back pops.
        head[0] = pc_pack(32'h100);
        head[1] = pc_pack(32'h200);
        hvld[0] = 1'b1;
        hvld[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("rr_seq%0d", i), 64'(last_grant), 64'(i % 2));
        end

        // Stall for three cycles.
        pop_in = 1'b0;
        repeat (3) step();
        chk("stall3", 64'(sched_if.perf_stall_count), PERF ? 64'd3 : 64'd0);
        chk("stall_pc", 64'(sched_if.issue_alu_fifo_data_out.pc), 64'h200);

        // Flush wins over pop and valid requests; pointer is kept.
        pop_in = 1'b1;
        cf_en  = 1'b1;
        cf_fl  = 1'b1;
        step();
        chk("flush_nogrant", 64'(last_grant + 1), 64'd0);
        cf_en = 1'b0;
        cf_fl = 1'b0;
        step();
        chk("flush_resume", 64'(last_grant), 64'd0);

        // Stall with rr_ptr=1, then reset mid-stall.
        pop_in = 1'b0;
        step();
        do_reset();

        // Counter pattern: 5 grants to requester 0, 3 to requester 1.
        pop_in = 1'b1;
        step();
        chk("reset_first", 64'(last_grant), 64'd0);
        repeat (5) step();
        hvld[1] = 1'b0;
        repeat (2) step();
        chk("grant_cnt0", 64'(sched_if.perf_grant_count[0]), PERF ? 64'd5 : 64'd0);
        chk("grant_cnt1", 64'(sched_if.perf_grant_count[1]), PERF ? 64'd3 : 64'd0);

        // Randomized traffic with stable heads until popped.
        for (int n = 0; n < 400; n++) begin
            pop_in = ($urandom_range(0, 99) < 70);
            cf_en  = ($urandom_range(0, 99) < 15);
            cf_fl  = ($urandom_range(0, 99) < 60);
            step();
            if (last_grant >= 0) begin
                head[last_grant] = rand_pack();
                hvld[last_grant] = 1'($urandom_range(0, 1));
            end
            for (int k = 0; k < REQ; k++) begin
                if (!hvld[k] && $urandom_range(0, 1) == 1) begin
                    head[k] = rand_pack();
                    hvld[k] = 1'b1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_alu_scheduler.md
# execute_alu_scheduler

Shares one `execute_alu` instance among `REQ_NUM` issue queues. A round-robin grant picks which queue feeds the ALU, and a one-entry holding register presents the chosen `issue_execute_pack_t` to the ALU's issue-FIFO-side port. The block sits between the issue stage's per-queue ALU FIFOs and `execute_alu`, and drops in-flight work on a commit flush.

## Interface
Parameters:
- `REQ_NUM`, default 2 — number of requesting issue queues, ≥2.
- `PTR_W`, default `$clog2(REQ_NUM)` — round-robin pointer width.

Ports (all synchronous to `clk`; one clock domain):
- `clk`  in  1  — clock.
- `rst`  in  1  — reset, asynchronous, active-low: asserted at 0, released at 1.
- `req_data_out[REQ_NUM]`  in  `issue_execute_pack_t` — head entry of each requester FIFO.
- `req_data_out_valid[REQ_NUM]`  in  1 each — requester head is valid.
- `req_pop[REQ_NUM]`  out  1 each — combinational; pops the granted requester this cycle.
- `issue_alu_fifo_data_out`  out  `issue_execute_pack_t` — holding register contents, to `execute_alu`.
- `issue_alu_fifo_data_out_valid`  out  1 — holding register full.
- `issue_alu_fifo_pop`  in  1 — `execute_alu` consumed the holding register this cycle.
- `commit_feedback_pack`  in  `commit_feedback_pack_t` — flush source.
- `perf_grant_count[REQ_NUM]`  out  32 each — grants per requester; 0 without the macro.
- `perf_stall_count`  out  32 — cycles spent in STALL; 0 without the macro.

## Operation
- `flush = commit_feedback_pack.enable & commit_feedback_pack.flush`.
- `load_en = ~flush & (~hold_valid | issue_alu_fifo_pop)`.
- States, derived from `hold_valid` and inputs:
  - EMPTY: `hold_valid=0`.
  - FULL: `hold_valid=1` and pop asserted.
  - STALL: `hold_valid=1` and no pop.
- Grant when `load_en`:
  - Search `req_data_out_valid` starting at `rr_ptr`, ascending, wrapping modulo `REQ_NUM`.
  - The first valid requester `g` is granted.
  - `req_pop[g]=1`; all other `req_pop` bits are 0.
  - On the edge: holding register ← `req_data_out[g]`, `hold_valid←1`, `rr_ptr ← (g+1) mod REQ_NUM`.
- `load_en` with no valid requester: `hold_valid←0` on the edge, `rr_ptr` unchanged.
- STALL: all `req_pop=0`; the holding register and `rr_ptr` are held.
- Flush: all `req_pop=0`; `hold_valid←0` on the edge.
  - Flush wins over a simultaneous `issue_alu_fifo_pop` and over valid requests.
  - `rr_ptr` is unchanged.
- Packs pass through bit-exact, including `enable=0` packs. The block does not inspect pack fields.
- Reset (asynchronous, at any time, including mid-stall):
  - `hold_valid=0`, holding register all-zero, `rr_ptr=0`, perf counters 0.
  - All `req_pop=0` while `rst=0`.
  - Therefore `issue_alu_fifo_data_out_valid=0` and `issue_alu_fifo_data_out='0`.

## Timing
- Latency: a request valid in cycle t while EMPTY gets `req_pop=1` in t and `issue_alu_fifo_data_out_valid=1` in t+1.
- Throughput is one pack per cycle: pop and reload happen in the same cycle with no bubble.
- `req_pop` depends combinationally on `req_data_out_valid`, `issue_alu_fifo_pop`, `commit_feedback_pack` and state. There is no combinational path from `req_data_out` to any output.
- Requesters must hold their head stable until popped.

## Configuration
- `ALU_SCHED_PERF_COUNTER_EN` defined:
  - `perf_grant_count[g]` increments by 1 on each grant edge.
  - `perf_stall_count` increments by 1 every cycle in STALL.
  - Both counters wrap modulo 2^32 and are cleared by reset only; flush does not clear them.
- Macro undefined: the counters are not instantiated and the outputs are tied to 0. Port list is identical in both builds.

## Test plan
- Reset: `rst=0` mid-stall with both requests valid → next sample shows `issue_alu_fifo_data_out_valid=0`, all `req_pop=0`, `rr_ptr=0`; after release the first grant goes to requester 0.
- Single request: only requester 1 valid with pc=0x80, pop tied 1 → `req_pop[1]=1` in t; output pc=0x80 and valid=1 in t+1.
- Round-robin: both valid continuously, pop=1 → grants alternate 0,1,0,1; no idle cycle between outputs.
- Stall: hold full, pop=0 for 3 cycles, requests valid → `req_pop=0` throughout, output stable, `perf_stall_count=3` with the macro, 0 without.
- Flush: flush=1 together with pop=1 and both requests valid → no `req_pop`, valid=0 next cycle, next grant resumes at the unchanged `rr_ptr`.
- Counters with the macro: 5 grants to requester 0 and 3 to requester 1 → `perf_grant_count = {5, 3}`.
